// File: rtl/clk_en_pkg.sv
// rtl/clk_en_pkg.sv - shared state encodings, STATUS bit indices and default widths for clk_en_synth
//
// Purpose : common definitions for the clock-enable synthesiser and its
//           per-channel accumulator.
// Contents: state_t (SETTLE/RUN/APPLY), STATUS field indices, DEF_ACC_W.
package clk_en_pkg;

    localparam int DEF_ACC_W = 16;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_APPLY  = 2'd2
    } state_t;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_STATE_MSB = 1;
    localparam int STAT_CFG_ERR   = 2;
    localparam int STAT_RSVD      = 3;

endpackage

// File: rtl/clk_en_acc.sv
// rtl/clk_en_acc.sv - one fractional-rate enable channel (MULT/DIV phase accumulator)
//
// Purpose : holds one channel's MULT/DIV ratio and accumulator; emits a
//           registered enable strobe at average rate MULT/DIV while run=1.
// Ports   : clk, reset (sync, active-high)
//           clear - zero the accumulator and enable
//           run   - advance the accumulator this cycle
//           load  - capture mult/div as the new ratio
//           mult, div - new ratio values (used with load)
//           en    - registered enable strobe
module clk_en_acc
    import clk_en_pkg::*;
#(
    parameter int               ACC_W    = DEF_ACC_W,
    parameter logic [ACC_W-1:0] DEF_MULT = 1,
    parameter logic [ACC_W-1:0] DEF_DIV  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic             load,
    input  logic [ACC_W-1:0] mult,
    input  logic [ACC_W-1:0] div,
    output logic             en
);

    logic [ACC_W-1:0] mult_q, mult_d;
    logic [ACC_W-1:0] div_q,  div_d;
    logic [ACC_W-1:0] acc_q,  acc_d;
    logic             en_q,   en_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        mult_d = mult_q;
        div_d  = div_q;
        acc_d  = acc_q;
        en_d   = 1'b0;
        // One extra bit so acc + MULT never wraps, even at MULT = DIV = all ones.
        sum    = {1'b0, acc_q} + {1'b0, mult_q};

        if (load) begin
            mult_d = mult;
            div_d  = div;
        end

        if (clear) begin
            acc_d = '0;
        end else if (run) begin
            if (sum >= {1'b0, div_q}) begin
                // acc < DIV and MULT <= DIV keep the remainder below DIV,
                // so it always fits back into ACC_W bits.
                acc_d = ACC_W'(sum - {1'b0, div_q});
                en_d  = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mult_q <= DEF_MULT;
            div_q  <= DEF_DIV;
            acc_q  <= '0;
            en_q   <= 1'b0;
        end else begin
            mult_q <= mult_d;
            div_q  <= div_d;
            acc_q  <= acc_d;
            en_q   <= en_d;
        end
    end

    assign en = en_q;

endmodule

// File: rtl/clk_en_synth.sv
// rtl/clk_en_synth.sv - fractional-rate clock-enable synthesiser with lock and runtime reconfiguration
//
// Purpose : derives NUM_CH enable strobes at MULT/DIV of CLK_IN1, signals
//           LOCKED after a settle period, and re-settles all channels
//           phase-aligned whenever a channel is reconfigured.
// Ports   : CLK_IN1   system clock
//           RESET     synchronous active-high reset
//           cfg_wr / cfg_ch / cfg_mult / cfg_div   config write (taken when cfg_ready)
//           cfg_ready config port can accept (low only while applying)
//           en_o      per-channel registered enable strobes
//           LOCKED    strobes valid and phase-aligned
//           STATUS    [1:0] state, [2] sticky cfg_err, [3] zero
module clk_en_synth
    import clk_en_pkg::*;
#(
    parameter int                      NUM_CH      = 3,
    parameter int                      ACC_W       = DEF_ACC_W,
    parameter int                      LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_MULT    = {16'd1, 16'd4, 16'd1},
    parameter logic [NUM_CH*ACC_W-1:0] DEF_DIV     = {16'd4, 16'd10, 16'd1}
) (
    input  logic              CLK_IN1,
    input  logic              RESET,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_mult,
    input  logic [ACC_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] en_o,
    output logic              LOCKED,
    output logic [3:0]        STATUS
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             locked_q, locked_d;
    logic             cfg_err_q, cfg_err_d;

    logic             wr_take;
    logic             cfg_valid;
    logic             wr_ok;
    logic             wr_bad;
    logic             run;
    logic [3:0]       status;

    // ------------------------------------------------------------------
    // Config validation
    // ------------------------------------------------------------------
    always_comb begin
        wr_take   = cfg_wr && cfg_ready;
        cfg_valid = ({1'b0, cfg_ch} < 4'(NUM_CH)) &&
                    (cfg_div != '0) &&
                    (cfg_mult <= cfg_div);
        wr_ok     = wr_take && cfg_valid;
        wr_bad    = wr_take && !cfg_valid;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN1) begin
        if (RESET) begin
            state_q   <= ST_SETTLE;
            cnt_q     <= '0;
            locked_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            locked_q  <= locked_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        cfg_err_d = cfg_err_q | wr_bad;

        case (state_q)
            ST_SETTLE: begin
                // A new config restarts settling via APPLY, even on the
                // cycle that would otherwise have locked.
                if (wr_ok) begin
                    state_d = ST_APPLY;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (wr_ok) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_SETTLE;
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase

        locked_d = (state_d == ST_RUN);
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready = (state_q != ST_APPLY);
        run       = (state_q == ST_RUN);

        status                                = '0;
        status[STAT_STATE_MSB:STAT_STATE_LSB] = state_q;
        status[STAT_CFG_ERR]                  = cfg_err_q;
        status[STAT_RSVD]                     = 1'b0;
    end

    assign LOCKED = locked_q;
    assign STATUS = status;

    // ------------------------------------------------------------------
    // Channels: every valid write clears all accumulators so the channels
    // restart phase-aligned; only the addressed one takes the new ratio.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load;

        assign load = wr_ok && (cfg_ch == 3'(i));

        clk_en_acc #(
            .ACC_W    (ACC_W),
            .DEF_MULT (DEF_MULT[i*ACC_W +: ACC_W]),
            .DEF_DIV  (DEF_DIV[i*ACC_W +: ACC_W])
        ) u_acc (
            .clk   (CLK_IN1),
            .reset (RESET),
            .clear (wr_ok),
            .run   (run),
            .load  (load),
            .mult  (cfg_mult),
            .div   (cfg_div),
            .en    (en_o[i])
        );
    end

endmodule

// File: tb/tb_clk_en_synth.sv
// tb/tb_clk_en_synth.sv - directed self-checking bench for clk_en_synth
module tb_clk_en_synth;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 16;
    localparam int L      = 16;

    logic              clk = 1'b0;
    logic              RESET;
    logic              cfg_wr;
    logic [2:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_mult;
    logic [ACC_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic [NUM_CH-1:0] en_o;
    logic              LOCKED;
    logic [3:0]        STATUS;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    clk_en_synth #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (L),
        .DEF_MULT    ({16'd1, 16'd4, 16'd1}),
        .DEF_DIV     ({16'd4, 16'd10, 16'd1})
    ) dut (
        .CLK_IN1   (clk),
        .RESET     (RESET),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_mult  (cfg_mult),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .en_o      (en_o),
        .LOCKED    (LOCKED),
        .STATUS    (STATUS)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Values observed after step() belong to the next cycle index.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [ACC_W-1:0] m, input logic [ACC_W-1:0] d);
        cfg_ch   = ch;
        cfg_mult = m;
        cfg_div  = d;
        cfg_wr   = 1'b1;
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic wait_lock(input string tag);
        int n;
        n = 0;
        while (!LOCKED && n < 40) begin
            step();
            n++;
        end
        check({tag, "_lock_timeout"}, {31'd0, LOCKED}, 32'd1);
    endtask

    // Expects to be called at cycle 0 with default ratios loaded.
    task automatic run_lock_check(input string tag);
        logic [2:0] e;
        logic       l;
        check({tag, "_cycle0"}, {LOCKED, cfg_ready, STATUS, en_o}, {1'b0, 1'b1, 4'b0000, 3'b000});
        for (int c = 1; c <= 30; c++) begin
            step();
            l    = (c >= L);
            e[0] = (c >= L + 1);
            e[1] = (c >= L + 3) && (((c - (L + 3)) % 5 == 0) || ((c - (L + 3)) % 5 == 2));
            e[2] = (c >= L + 4) && ((c - (L + 4)) % 4 == 0);
            check($sformatf("%s_seq_c%0d", tag, c), {LOCKED, en_o}, {l, e});
        end
    endtask

    initial begin
        logic [2:0] tbl [1:7];
        logic       hist [0:6];
        int         cnt0, cnt1, cnt2, per_bad, lk_bad;

        RESET    = 1'b1;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_mult = '0;
        cfg_div  = '0;

        // ---------------- reset release with defaults ----------------
        repeat (3) step();
        RESET = 1'b0;
        cyc   = 0;
        run_lock_check("defaults");

        // ---------------- reconfigure ch1 to 3/7 while running --------
        cfg_write(3'd1, 16'd3, 16'd7);
        check("apply_locked",  {31'd0, LOCKED},    32'd0);
        check("apply_ready",   {31'd0, cfg_ready}, 32'd0);
        check("apply_status",  {28'd0, STATUS},    32'h2);
        step();
        check("settle_status", {28'd0, STATUS},    32'h0);
        check("settle_ready",  {31'd0, cfg_ready}, 32'd1);
        repeat (L - 1) step();
        check("relock_early",  {31'd0, LOCKED},    32'd0);
        step();
        check("relock",        {31'd0, LOCKED},    32'd1);
        check("relock_en0",    {29'd0, en_o},      32'd0);

        // First period after relock: ch0 1/1, ch1 3/7, ch2 1/4 from acc=0.
        tbl[1] = 3'b001; tbl[2] = 3'b001; tbl[3] = 3'b011; tbl[4] = 3'b101;
        tbl[5] = 3'b011; tbl[6] = 3'b001; tbl[7] = 3'b011;
        cnt0 = 0; cnt1 = 0; cnt2 = 0; per_bad = 0;
        for (int o = 1; o <= 7000; o++) begin
            step();
            if (o <= 7) check($sformatf("aligned_o%0d", o), {29'd0, en_o}, {29'd0, tbl[o]});
            else if (hist[o % 7] !== en_o[1]) per_bad++;
            hist[o % 7] = en_o[1];
            cnt0 += int'(en_o[0]);
            cnt1 += int'(en_o[1]);
            cnt2 += int'(en_o[2]);
        end
        check("rate_ch1_count", cnt1, 32'd3000);
        check("rate_ch1_period", per_bad, 32'd0);
        check("rate_ch0_count", cnt0, 32'd7000);
        check("rate_ch2_count", cnt2, 32'd1750);

        // ---------------- invalid configs while locked ----------------
        cfg_write(3'd1, 16'd1, 16'd0);
        check("bad_div0_locked", {31'd0, LOCKED}, 32'd1);
        check("bad_div0_status", {28'd0, STATUS}, 32'h5);
        cfg_write(3'd2, 16'd5, 16'd4);
        check("bad_m_gt_d_locked", {31'd0, LOCKED}, 32'd1);
        check("bad_m_gt_d_status", {28'd0, STATUS}, 32'h5);
        cfg_write(3'd3, 16'd1, 16'd2);
        check("bad_ch_locked", {31'd0, LOCKED}, 32'd1);
        check("bad_ch_status", {28'd0, STATUS}, 32'h5);
        cnt1 = 0; cnt2 = 0; lk_bad = 0;
        for (int o = 0; o < 28; o++) begin
            step();
            cnt1 += int'(en_o[1]);
            cnt2 += int'(en_o[2]);
            if (!LOCKED) lk_bad++;
        end
        check("bad_keep_ch1", cnt1, 32'd12);
        check("bad_keep_ch2", cnt2, 32'd7);
        check("bad_keep_lock", lk_bad, 32'd0);

        // ---------------- RESET mid-SETTLE after a runtime write ------
        cfg_write(3'd0, 16'd1, 16'd2);
        repeat (5) step();
        check("mid_settle_status", {28'd0, STATUS}, 32'h4);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        cyc   = 0;
        run_lock_check("rst_mid");

        // ---------------- edge ratios ----------------
        cfg_write(3'd0, 16'd0, 16'd5);
        wait_lock("mult0");
        cnt0 = 0; lk_bad = 0;
        for (int o = 0; o < 50; o++) begin
            step();
            cnt0 += int'(en_o[0]);
            if (!LOCKED) lk_bad++;
        end
        check("mult0_count", cnt0, 32'd0);
        check("mult0_lock", lk_bad, 32'd0);

        cfg_write(3'd1, 16'hFFFF, 16'hFFFF);
        wait_lock("full");
        cnt0 = 0; cnt1 = 0;
        for (int o = 0; o < 50; o++) begin
            step();
            cnt0 += int'(en_o[0]);
            cnt1 += int'(en_o[1]);
        end
        check("full_ch1_count", cnt1, 32'd50);
        check("full_ch0_still0", cnt0, 32'd0);

        // ---------------- RESET coincident with cfg_wr ----------------
        RESET    = 1'b1;
        cfg_ch   = 3'd0;
        cfg_mult = 16'd0;
        cfg_div  = 16'd1;
        cfg_wr   = 1'b1;
        step();
        RESET  = 1'b0;
        cfg_wr = 1'b0;
        cyc    = 0;
        run_lock_check("rst_wr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_en_synth.md
# clk_en_synth

Parametrised clock-enable synthesiser: from the single system clock it derives NUM_CH fractional-rate enable strobes, each at rate MULT/DIV of the input clock, with a lock indicator and runtime reconfiguration. It replaces fixed multiply/divide clock primitives wherever the derived rates are consumed as enables in the main clock domain, such as the 100/40/25 MHz video and system rates. Reconfiguring a channel triggers a global re-settle, after which all channels restart phase-aligned.

## Interface
- NUM_CH, 3: number of enable channels (1..8)
- ACC_W, 16: width of MULT, DIV and the accumulators
- LOCK_CYCLES, 16: settle cycles before LOCKED asserts (≥1)
- DEF_MULT, {16'd1,16'd4,16'd1}: reset MULT per channel, flattened, ch0 in LSBs
- DEF_DIV, {16'd4,16'd10,16'd1}: reset DIV per channel, flattened (ch0 = 1/1, ch1 = 2/5, ch2 = 1/4)

Ports:
- CLK_IN1  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- cfg_wr  in  1  config write strobe; accepted when cfg_wr && cfg_ready
- cfg_ch  in  3  target channel
- cfg_mult  in  ACC_W  new MULT
- cfg_div  in  ACC_W  new DIV
- cfg_ready  out  1  config port can accept
- en_o  out  NUM_CH  per-channel enable strobes, registered
- LOCKED  out  1  outputs valid and phase-aligned
- STATUS  out  4  [1:0] state, [2] sticky cfg_err, [3] reserved 0

## Operation
- FSM states: SETTLE=2'd0, RUN=2'd1, APPLY=2'd2.
- RESET: state SETTLE, settle counter 0, all accumulators 0, MULT/DIV loaded from DEF_*, cfg_err 0.
- Reset values of outputs: en_o=0, LOCKED=0, cfg_ready=1, STATUS=4'b0000.
- SETTLE: the counter increments each cycle. When it reaches LOCK_CYCLES-1, the FSM moves to RUN and LOCKED is registered high. en_o is held 0 in SETTLE.
- RUN, per channel, every cycle: sum = acc + MULT, computed at ACC_W+1 bits with no overflow.
  - If sum ≥ DIV: acc ← sum − DIV, and en_o[ch] is registered 1.
  - Otherwise: acc ← sum, and en_o[ch] is registered 0.
- Config write accepted in SETTLE or RUN:
  - Valid means cfg_ch < NUM_CH, cfg_div ≠ 0 and cfg_mult ≤ cfg_div. A write failing this is ignored and sets STATUS[2], which is cleared only by RESET.
  - A valid write moves the FSM to APPLY: the target MULT/DIV is written, all accumulators are cleared, LOCKED←0, en_o←0, cfg_ready←0.
  - The next state is always SETTLE with the counter cleared.
- A valid write during SETTLE restarts the settle count.
- cfg_ready is 0 only in APPLY.
- MULT=0 gives en_o permanently 0 while LOCKED. MULT=DIV gives en_o permanently 1 while LOCKED.
- RESET mid-operation, including in APPLY: reset values apply on the next edge, and runtime config is discarded in favour of DEF_*.
- Simultaneous RESET and cfg_wr: RESET wins and the write is dropped.

## Timing
- Cycle 0 is the first edge with RESET sampled low.
- LOCKED is high from cycle LOCK_CYCLES onward.
- The first accumulation occurs at cycle LOCK_CYCLES. en_o reflects the accumulation of the previous cycle, so latency is 1.
- Default ch0 (1/1): en_o[0]=1 from cycle L+1, where L = LOCK_CYCLES.
- Default ch1 (4/10, i.e. 2/5): pattern 0,0,1,0,1 repeating. First 1 at cycle L+3, then L+5, L+8, L+10.
- Default ch2 (1/4): first 1 at cycle L+4, then every 4 cycles.
- Config accepted at edge N: APPLY during cycle N+1 and SETTLE from N+2. LOCKED is high again at cycle N+2+LOCK_CYCLES.
- Long-run pulse count over any DIV·k window while locked is exactly MULT·k, with no drift.

## Structure
- Shared package/header clk_en_pkg holds:
  - state encodings SETTLE/RUN/APPLY;
  - STATUS bit indices;
  - the default ACC_W.
- Sub-module clk_en_acc: one channel with its MULT/DIV registers, accumulator, comparator and registered en. Ports: clk, reset, clear, run, load, mult, div, en. Instantiated NUM_CH times via generate.
- Top level holds the FSM, settle counter, config validation and STATUS.

## Test plan
- Reset release with defaults and LOCK_CYCLES=16:
  - LOCKED rises at cycle 16.
  - en_o[0]=1 from 17.
  - en_o[1] pulses at 19, 21, 24, 26.
  - en_o[2] pulses at 20, 24, 28.
- Rate accuracy: write ch1 MULT=3, DIV=7, then run 7000 cycles -> exactly 3000 pulses on en_o[1], and the pattern is periodic in 7 cycles.
- Invalid configs (cfg_div=0; MULT=5, DIV=4; cfg_ch=3 with NUM_CH=3) -> ignored, STATUS[2]=1, LOCKED stays 1, outputs unchanged.
- Reconfigure while running: valid write at edge N -> LOCKED=0 at N+1, cfg_ready=0 during N+1, LOCKED=1 at N+2+16, all channels restart aligned from acc=0.
- RESET pulsed mid-SETTLE after a runtime write -> config reverts to DEF_*, STATUS=0, lock timing identical to the first scenario.
- Edge ratios: MULT=0 -> en_o stays 0; MULT=DIV=65535 -> en_o stays 1. Also RESET coincident with cfg_wr -> write dropped.
